// File: rtl/bitutils.sv
// Shared definitions for the carry-less multiply datapath: op encoding, FSM states
// and the XLEN/STEP legality rule checked at elaboration by the multiplier.
package bitutils;

  typedef enum logic [1:0] {
    CLMUL      = 2'd0,
    CLMULH     = 2'd1,
    CLMULR     = 2'd2,
    CLMUL_RSVD = 2'd3
  } clmul_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } clmul_state_t;

  function automatic bit clmul_cfg_legal(input int xlen, input int step);
    return ((xlen == 32) || (xlen == 64)) && (step > 0) &&
           ((step & (step - 1)) == 0) && ((xlen % step) == 0);
  endfunction

endpackage

// File: rtl/clmul_iter_unit_if.sv
// Request/response bundle for the iterative carry-less multiplier.
// Valid/ready on both sides; master is the issue port, slave is the unit.
interface clmul_iter_unit_if
  import bitutils::*;
#(
  parameter int XLEN = 32
) ();
  logic              in_valid;
  logic              in_ready;
  clmul_op_t         op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/clmul_step.sv
// One iteration of GF(2) shift-and-add: folds STEP bits of A into the accumulator.
// Purely combinational, no backpressure.
module clmul_step #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [STEP-1:0]   a_bits,
  input  logic [2*XLEN-1:0] b_sh,
  input  logic [2*XLEN-1:0] acc,
  output logic [2*XLEN-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < STEP; j++) begin
      if (a_bits[j]) begin
        acc_next = acc_next ^ (b_sh << j);
      end
    end
  end

endmodule

// File: rtl/clmul_iter_unit.sv
// Iterative clmul/clmulh/clmulr, STEP A-bits per cycle with early exit; latency 1+N cycles.
// Holds result/out_valid in DONE until out_ready; in_ready only in IDLE; flush kills any state.
module clmul_iter_unit
  import bitutils::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input logic              CLK,
  input logic              nRST,
  input logic              flush,
  clmul_iter_unit_if.slave bus
);

  if (!clmul_cfg_legal(XLEN, STEP)) begin : g_cfg_err
    $error("clmul_iter_unit: XLEN must be 32/64 and STEP a power of two dividing XLEN");
  end

  clmul_state_t      state_q, state_d;
  clmul_op_t         op_q;
  logic [XLEN-1:0]   a_rem;
  logic [XLEN-1:0]   a_rem_next;
  logic [2*XLEN-1:0] b_sh;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   result_q;
  logic              accept;
  logic              step_done;

  function automatic logic [XLEN-1:0] sel_result(input clmul_op_t op,
                                                 input logic [2*XLEN-1:0] p);
    case (op)
      CLMULH:  return p[2*XLEN-1:XLEN];
      CLMULR:  return p[2*XLEN-2:XLEN-1];
      default: return p[XLEN-1:0];
    endcase
  endfunction

  clmul_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .a_bits   (a_rem[STEP-1:0]),
    .b_sh     (b_sh),
    .acc      (acc),
    .acc_next (acc_next)
  );

  assign a_rem_next = a_rem >> STEP;
  assign step_done  = (a_rem_next == '0);
  assign accept     = (state_q == S_IDLE) && bus.in_valid && !flush;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (step_done) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Kill wins over both accept and the output handshake.
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q     <= CLMUL;
      a_rem    <= '0;
      b_sh     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      a_rem <= bus.a;
      b_sh  <= {{XLEN{1'b0}}, bus.b};
      acc   <= '0;
    end else if ((state_q == S_BUSY) && !flush) begin
      acc   <= acc_next;
      a_rem <= a_rem_next;
      b_sh  <= b_sh << STEP;
      if (step_done) begin
        result_q <= sel_result(op_q, acc_next);
      end
    end
  end

endmodule

// File: tb/tb_clmul_iter_unit.sv
// Directed vector table plus hand sequences for backpressure, flush, reset and idle-flush.
module tb_clmul_iter_unit;
  import bitutils::*;

  logic CLK;
  logic nRST;
  logic flush;
  int   checks;
  int   errors;

  clmul_iter_unit_if #(.XLEN(32)) bus ();

  clmul_iter_unit #(
    .XLEN (32),
    .STEP (4)
  ) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    clmul_op_t   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input clmul_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid is seen at a negedge.
  task automatic wait_valid(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
  endtask

  task automatic no_valid(input string name, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      if (bus.out_valid) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic run_vec(input int idx);
    int lat;
    bit got;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge CLK);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    start(vecs[idx].op, vecs[idx].a, vecs[idx].b);
    wait_valid(lat, got);
    if (!got) begin
      chk({nm, "_timeout"}, 32'(got), 32'd1);
    end else begin
      chk({nm, "_result"}, bus.result, vecs[idx].exp);
      chk({nm, "_latency"}, 32'(lat), 32'(vecs[idx].lat));
      bus.out_ready = 1'b1;
      @(posedge CLK);
      #1;
      bus.out_ready = 1'b0;
      @(negedge CLK);
      chk({nm, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({nm, "_result_hold"}, bus.result, vecs[idx].exp);
    end
  endtask

  initial begin
    int  lat;
    bit  got;

    checks = 0;
    errors = 0;

    vecs[0]  = '{CLMUL,      32'h0000_0003, 32'h0000_0003, 32'h0000_0005, 2};
    vecs[1]  = '{CLMUL,      32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 9};
    vecs[2]  = '{CLMULH,     32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9};
    vecs[3]  = '{CLMULR,     32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 9};
    vecs[4]  = '{CLMUL,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 9};
    vecs[5]  = '{CLMULH,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 9};
    vecs[6]  = '{CLMULR,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 9};
    vecs[7]  = '{CLMUL_RSVD, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 2};
    vecs[8]  = '{CLMUL,      32'h0000_0005, 32'h0000_0007, 32'h0000_001B, 2};
    vecs[9]  = '{CLMUL,      32'h0000_0010, 32'h0000_0001, 32'h0000_0010, 3};
    vecs[10] = '{CLMUL,      32'h0000_0100, 32'h0000_000F, 32'h0000_0F00, 4};
    vecs[11] = '{CLMULH,     32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 9};
    vecs[12] = '{CLMULR,     32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 2};
    vecs[13] = '{CLMULR,     32'h0000_1000, 32'h0010_0000, 32'h0000_0002, 5};

    nRST          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = CLMUL;
    bus.a         = '0;
    bus.b         = '0;

    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_vec(i);
    end

    // Backpressure: DONE held 5 cycles with a second request already waiting.
    start(CLMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat, got);
    chk("bp_got_valid", 32'(got), 32'd1);
    bus.op       = CLMUL;
    bus.a        = 32'h0000_0003;
    bus.b        = 32'h0000_0003;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_result_%0d", i), bus.result, 32'h5555_5555);
      @(negedge CLK);
    end
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    chk("bp_bubble_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_bubble_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("bp_second_busy", 32'(bus.in_ready), 32'd0);
    lat = 1;
    got = bus.out_valid;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    chk("bp_second_got", 32'(got), 32'd1);
    chk("bp_second_lat", 32'(lat), 32'd2);
    chk("bp_second_result", bus.result, 32'h0000_0005);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;

    // Flush during the third BUSY cycle.
    start(CLMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge CLK);
    chk("fl_busy", 32'(bus.in_ready), 32'd0);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    @(negedge CLK);
    chk("fl_idle", 32'(bus.in_ready), 32'd1);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_result_kept", bus.result, 32'h0000_0005);
    no_valid("fl_no_valid", 12);

    // Reset pulse during the third BUSY cycle.
    start(CLMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("rp_result", bus.result, 32'd0);
    chk("rp_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rp_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    no_valid("rp_no_valid", 12);

    // Flush alongside a request in IDLE must not accept it.
    @(negedge CLK);
    bus.op       = CLMUL;
    bus.a        = 32'h0000_0003;
    bus.b        = 32'h0000_0003;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    @(negedge CLK);
    chk("if_no_accept", 32'(bus.in_ready), 32'd1);
    no_valid("if_no_valid", 6);

    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clmul_iter_unit.md
# clmul_iter_unit

Iterative, parametrised carry-less multiplier for the Zbc execute path. It computes `clmul`, `clmulh` and `clmulr` for XLEN = 32 or 64, retiring STEP bits of operand A per cycle, and exits early once the remaining A bits are zero. The unit sits behind the ALU issue port with valid/ready handshakes on both sides. It replaces the fixed 32-bit single-stage multiplier where area matters more than latency.

## Interface

Parameters:
- `XLEN`, default 32: operand/result width. Legal values are 32 and 64.
- `STEP`, default 4: A bits consumed per BUSY cycle. Must be a power of two that divides XLEN.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `nRST`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `op`  in  `clmul_op_t` (2)  CLMUL=0, CLMULH=1, CLMULR=2; 3 is treated as CLMUL.
- `a`  in  XLEN  multiplicand A.
- `b`  in  XLEN  multiplicand B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  XLEN  registered result.

## Operation

The control FSM has three states: IDLE, BUSY and DONE.
- **IDLE:**
  - Accept when `in_valid && !flush`.
  - On accept: latch `op`; `a_rem <= a`; `b_sh <= {XLEN'0, b}` (2·XLEN wide); `acc <= 0`; go to BUSY.
- **BUSY, each cycle:**
  - `acc ^= XOR over j<STEP of (a_rem[j] ? b_sh << j : 0)`.
  - `a_rem >>= STEP`; `b_sh <<= STEP`.
  - If the updated `a_rem == 0`, load `result` and go to DONE. Otherwise stay in BUSY.
- **Result select, from the final P = acc (2·XLEN bits):**
  - CLMUL: `P[XLEN-1:0]`.
  - CLMULH: `P[2XLEN-1:XLEN]`.
  - CLMULR: `P[2XLEN-2:XLEN-1]`.
- **DONE:**
  - `out_valid = 1`.
  - On `out_ready`, go to IDLE.
  - `in_ready = 0`, so DONE → IDLE → accept costs one bubble cycle.
- **flush:**
  - In any state, the next state is IDLE, `out_valid` drops next cycle, and the operation is discarded.
  - Flush has priority over a simultaneous accept and over `out_ready`.
  - `result` is not modified by flush.
- **Arithmetic rules:**
  - All arithmetic is GF(2): XOR only, no carries.
  - `acc` and `b_sh` are 2·XLEN bits wide; bits shifted beyond bit 2·XLEN-1 are discarded. They can only ever be zero partial products.

## Timing

- **Reset values:** state = IDLE, `out_valid` = 0, `result` = 0, `acc`/`a_rem`/`b_sh` = 0. `in_ready` = 1 while and after reset.
- **Reset mid-operation:** `nRST` asserted mid-operation aborts immediately, asynchronously. No `out_valid` is produced for the aborted operation.
- **BUSY cycle count:** N = max(1, ceil((h+1)/STEP)), where h is the index of the highest set bit of A. A = 0 gives N = 1.
- **Latency:**
  - Accept in cycle T gives `out_valid` high in cycle T+1+N.
  - Minimum 2 cycles; maximum XLEN/STEP + 1 (9 for 32/4, 17 for 64/4).
- **Stability in DONE:** `result` and `out_valid` are stable until `out_ready` is sampled high.
- **Stability in IDLE:** `result` holds its last value.
- **Input-side handshake:** a transfer occurs on a cycle with `in_valid && in_ready && !flush`. Operands need only be valid in that cycle.
- **Output-side handshake:** a transfer occurs on a cycle with `out_valid && out_ready && !flush`.

## Structure

- **Shared package `bitutils`:** holds `clmul_op_t` (2-bit enum above) and the `STEP`/`XLEN` legality checks as elaboration-time assertions.
- **Sub-module `clmul_step`:**
  - Combinational.
  - Inputs: `STEP` bits of A, the 2·XLEN shifted B, and the current accumulator.
  - Output: the next accumulator.
  - Parametrised by XLEN and STEP.
- **Top level:** holds the FSM, operand registers, result mux and handshakes.

## Test plan

All scenarios use XLEN = 32, STEP = 4.
1. **Minimum-latency CLMUL:** CLMUL a=0x00000003, b=0x00000003 → result 0x00000005; `out_valid` 2 cycles after accept.
2. **High-bit operands, all three ops:** a=0x80000000, b=0x80000000, `out_valid` 9 cycles after accept in each case:
   - CLMUL → 0x00000000.
   - CLMULH → 0x40000000.
   - CLMULR → 0x80000000.
3. **All-ones operands:** a=b=0xFFFFFFFF.
   - CLMUL → 0x55555555.
   - CLMULH → 0x55555555.
   - Latency 9 cycles.
4. **Output backpressure:** hold `out_ready` low 5 cycles in DONE with `in_valid` high.
   - `result` stable, `out_valid` stable at 1, `in_ready` = 0, no second accept.
   - After `out_ready`: one IDLE cycle, then the next accept.
5. **Flush and reset mid-operation:**
   - `flush` in the 3rd BUSY cycle of a=0xFFFFFFFF → IDLE next cycle, no `out_valid`, `result` unchanged.
   - Repeat with `nRST` pulsed instead → `result` = 0, `out_valid` = 0.
6. **Zero operand and reserved op:** a=0, b=0x12345678, op=3 → result 0x00000000 (CLMUL behaviour); `out_valid` 2 cycles after accept. Flush asserted together with `in_valid` in IDLE → no accept.
